// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// Module   : fifo_rd_pkg
// Purpose  : Shared types and constants for the FIFO read-side stream adapter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int CNT_W      = 32;

  // Index width for a table of 'depth' entries; a single entry still needs one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_skid_buf.sv
// ============================================================================
// Module   : fifo_rd_skid_buf
// Purpose  : Power-of-two circular elastic buffer landing FIFO read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = idx_w(DEPTH),
  localparam int CNT_BW = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_BW-1:0] count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_BW-1:0] r_count;
  logic              w_pop;

  // A pop against an empty buffer is ignored so the count can never underflow.
  assign w_pop = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({push, w_pop})
        2'b10:   r_count <= r_count + CNT_BW'(1);
        2'b01:   r_count <= r_count - CNT_BW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !w_pop && (r_count == CNT_BW'(DEPTH))));

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream_adapter.sv
// ============================================================================
// Module   : fifo_rd_stream_adapter
// Purpose  : Standard-mode FIFO read engine presenting words as a valid/ready
//            stream; optional delivered-word counter under FIFO_RD_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_stream_adapter
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH    = 4
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int c_cnt_w = idx_w(BUF_DEPTH) + 1;
  localparam int c_sum_w = c_cnt_w + 1;

  rd_state_t                 r_state;
  logic [READ_LATENCY-1:0]   r_vld_pipe;
  logic [c_cnt_w-1:0]        w_buf_count;
  logic [c_cnt_w-1:0]        w_inflight;
  logic [c_sum_w-1:0]        w_credit_sum;
  logic                      w_push;
  logic                      w_pop;

  // Words already requested count against buffer space so landing data always fits.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + c_cnt_w'(r_vld_pipe[i]);
    end
  end

  assign w_credit_sum = {1'b0, w_buf_count} + {1'b0, w_inflight};
  assign fifo_rd_en   = (r_state == RUN) && !fifo_empty
                        && (w_credit_sum < c_sum_w'(BUF_DEPTH));

  generate
    if (READ_LATENCY == 1) begin : g_lat_one
      always_ff @(posedge rd_clk) begin
        if (rst) begin
          r_vld_pipe <= '0;
        end else begin
          r_vld_pipe <= fifo_rd_en;
        end
      end
    end else begin : g_lat_multi
      always_ff @(posedge rd_clk) begin
        if (rst) begin
          r_vld_pipe <= '0;
        end else begin
          r_vld_pipe <= {r_vld_pipe[READ_LATENCY-2:0], fifo_rd_en};
        end
      end
    end
  endgenerate

  assign w_push = r_vld_pipe[READ_LATENCY-1];

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (ena) r_state <= RUN;
        RUN:     if (!ena) r_state <= DRAIN;
        DRAIN: begin
          if (ena) begin
            r_state <= RUN;
          end else if ((w_inflight == '0) && (w_buf_count == '0)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);

  fifo_rd_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_skid_buf (
    .clk       (rd_clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (fifo_dout),
    .pop       (w_pop),
    .head_data (m_data),
    .count     (w_buf_count)
  );

  assign m_valid = (w_buf_count != '0);
  assign w_pop   = m_valid && m_ready;

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] r_rd_count;

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      r_rd_count <= '0;
    end else if (w_pop) begin
      r_rd_count <= r_rd_count + CNT_W'(1);
    end
  end

  assign rd_count = r_rd_count;
`else
  assign rd_count = '0;
`endif

  a_no_underflow : assert property (@(posedge rd_clk) disable iff (rst)
    !(fifo_rd_en && fifo_empty));

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream_adapter.sv
// ============================================================================
// Module   : tb_fifo_rd_stream_adapter
// Purpose  : Self-checking bench with a behavioural FIFO and stream scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream_adapter;
  import fifo_rd_pkg::*;

  localparam int DATA_W = 8;
  localparam int RL     = 1;
  localparam int DEPTH  = 4;

  logic              rd_clk     = 1'b0;
  logic              rst        = 1'b1;
  logic              ena        = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_dout  = '0;
  logic              m_ready    = 1'b0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              busy;
  logic [CNT_W-1:0]  rd_count;

  int n_checks = 0;
  int n_fail   = 0;
  int xfers    = 0;
  int rd_cycles = 0;

  logic [DATA_W-1:0] fifo_q [$];
  logic [DATA_W-1:0] exp_q  [$];
  logic [DATA_W-1:0] pipe_d [RL];
  logic              empty_force = 1'b0;
  logic              prev_stall  = 1'b0;
  logic [DATA_W-1:0] prev_data   = '0;
  logic [CNT_W-1:0]  cnt0;

  fifo_rd_stream_adapter #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (RL),
    .BUF_DEPTH    (DEPTH)
  ) dut (
    .rd_clk     (rd_clk),
    .rst        (rst),
    .ena        (ena),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .rd_count   (rd_count)
  );

  always #5 rd_clk = ~rd_clk;

  // Behavioural FIFO (pops on rd_en, data appears RL cycles later) plus stream scoreboard.
  initial begin : model
    logic rd_s;
    logic rst_s;
    logic [DATA_W-1:0] e;
    for (int i = 0; i < RL; i++) pipe_d[i] = '0;
    forever begin
      @(negedge rd_clk);
      rst_s = rst;
      rd_s  = fifo_rd_en && !rst;
      if (!rst) begin
        rd_cycles += int'(fifo_rd_en);
        if (fifo_rd_en) begin
          n_checks++;
          if (fifo_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow: fifo_rd_en=1 with fifo_empty=%b (required 0)", fifo_empty);
          end
        end
        if (prev_stall) begin
          n_checks++;
          if (m_valid !== 1'b1 || m_data !== prev_data) begin
            n_fail++;
            $display("FAIL stall_hold: m_valid=%b m_data=%h required 1/%h", m_valid, m_data, prev_data);
          end
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
          xfers++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stream_data: got %h, required no transfer", m_data);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e) begin
              n_fail++;
              $display("FAIL stream_data: got %h required %h", m_data, e);
            end
          end
        end
        prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
        prev_data  = m_data;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge rd_clk);
      #2;
      if (rst_s) begin
        for (int i = 0; i < RL; i++) pipe_d[i] = '0;
      end else begin
        for (int i = RL - 1; i > 0; i--) pipe_d[i] = pipe_d[i-1];
        if (rd_s && fifo_q.size() > 0) pipe_d[0] = fifo_q.pop_front();
        else pipe_d[0] = '0;
      end
      fifo_dout  = pipe_d[RL-1];
      fifo_empty = (fifo_q.size() == 0) || empty_force;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge rd_clk);
      if (busy === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    ena = 1'b1;
    m_ready = 1'b1;
    push_word(8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(posedge rd_clk);
      @(negedge rd_clk);
      n_checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || m_data !== '0) begin
        n_fail++;
        $display("FAIL reset_state: rd_en=%b m_valid=%b busy=%b m_data=%h required 0/0/0/00",
                 fifo_rd_en, m_valid, busy, m_data);
      end
    end
    n_checks++;
    if (rd_count !== '0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d required 0", rd_count);
    end
    tick();
    ena = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single();
    bit ok;
    m_ready = 1'b1;
    push_word(8'hA5);
    repeat (3) tick();
    ena = 1'b1;
    @(negedge rd_clk);
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL single_c0_rd_en: got %b required 0", fifo_rd_en);
    end
    tick(); @(negedge rd_clk);
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL single_c1_rd_en: got %b required 1", fifo_rd_en);
    end
    tick(); @(negedge rd_clk);
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_c2_valid: got %b required 0", m_valid);
    end
    tick(); @(negedge rd_clk);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      n_fail++; $display("FAIL single_c3: m_valid=%b m_data=%h required 1/a5", m_valid, m_data);
    end
    tick();
    ena = 1'b0;
    wait_idle(20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL single_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_stream();
    int rd_first, rd_last, rd_n, x_first, x_last, x_n;
    bit ok;
    rd_first = -1; rd_last = -1; rd_n = 0;
    x_first = -1; x_last = -1; x_n = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(DATA_W'(i));
    repeat (3) tick();
    ena = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge rd_clk);
      if (fifo_rd_en === 1'b1) begin
        if (rd_first < 0) rd_first = c;
        rd_last = c; rd_n++;
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (x_first < 0) x_first = c;
        x_last = c; x_n++;
      end
      tick();
    end
    n_checks++;
    if (rd_n != 16 || rd_last - rd_first + 1 != 16) begin
      n_fail++; $display("FAIL stream_rd_en: %0d reads over span %0d required 16/16", rd_n, rd_last - rd_first + 1);
    end
    n_checks++;
    if (x_n != 16 || x_last - x_first + 1 != 16) begin
      n_fail++; $display("FAIL stream_gapless: %0d transfers over span %0d required 16/16", x_n, x_last - x_first + 1);
    end
    n_checks++;
    if (x_first - rd_first != RL + 1) begin
      n_fail++; $display("FAIL stream_latency: got %0d required %0d", x_first - rd_first, RL + 1);
    end
    ena = 1'b0;
    wait_idle(20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL stream_idle: busy=%b left=%0d required 0/0", busy, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int rd0, x0;
    bit ok;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) push_word(DATA_W'(8'h40 + i));
    repeat (3) tick();
    rd0 = rd_cycles; x0 = xfers;
    ena = 1'b1;
    repeat (15) tick();
    @(negedge rd_clk);
    n_checks++;
    if (rd_cycles - rd0 != DEPTH) begin
      n_fail++; $display("FAIL bp_accepted: got %0d reads required %0d", rd_cycles - rd0, DEPTH);
    end
    n_checks++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h40) begin
      n_fail++; $display("FAIL bp_hold: rd_en=%b m_valid=%b m_data=%h required 0/1/40", fifo_rd_en, m_valid, m_data);
    end
    tick();
    m_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0 || xfers - x0 != 20) begin
      n_fail++; $display("FAIL bp_release: %0d delivered, %0d left, required 20/0", xfers - x0, exp_q.size());
    end
    ena = 1'b0;
    wait_idle(20, ok);
  endtask

  task automatic test_empty_edge();
    int rd0;
    bit ok;
    for (int i = 0; i < 24; i++) push_word(DATA_W'($urandom));
    repeat (3) tick();
    rd0 = rd_cycles;
    ena = 1'b1;
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      if (c % 3 == 0) empty_force = ~empty_force;
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    empty_force = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0 || rd_cycles - rd0 != 24) begin
      n_fail++; $display("FAIL empty_edge: %0d left, %0d reads, required 0/24", exp_q.size(), rd_cycles - rd0);
    end
    ena = 1'b0;
    wait_idle(20, ok);
  endtask

  task automatic test_drain();
    int x0, popped, runc;
    bit ok;
    // Stalled stream: the full buffer must still be delivered after ena drops.
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(DATA_W'(8'h80 + i));
    repeat (3) tick();
    x0 = xfers; cnt0 = rd_count;
    ena = 1'b1;
    repeat (8) tick();
    ena = 1'b0;
    @(negedge rd_clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL drain_busy: got %b required 1", busy);
    end
    tick();
    m_ready = 1'b1;
    while (exp_q.size() > fifo_q.size()) begin
      if (exp_q.size() == 0) break;
      if (xfers - x0 >= DEPTH) break;
      tick();
      if (xfers - x0 > 40) break;
    end
    repeat (4) tick();
    @(negedge rd_clk);
    n_checks++;
    if (busy !== 1'b0 || xfers - x0 != DEPTH || fifo_q.size() != 10 - DEPTH) begin
      n_fail++; $display("FAIL drain_stalled: busy=%b delivered=%0d fifo_left=%0d required 0/%0d/%0d",
                         busy, xfers - x0, fifo_q.size(), DEPTH, 10 - DEPTH);
    end
`ifdef FIFO_RD_CNT_EN
    n_checks++;
    if (rd_count !== cnt0 + CNT_W'(DEPTH)) begin
      n_fail++; $display("FAIL drain_count: got %0d required %0d", rd_count, cnt0 + CNT_W'(DEPTH));
    end
`else
    n_checks++;
    if (rd_count !== '0) begin
      n_fail++; $display("FAIL count_tied: got %0d required 0", rd_count);
    end
`endif
    tick();
    fifo_q.delete();
    exp_q.delete();
    repeat (2) tick();
    // Randomised drop of ena while streaming: everything popped is delivered.
    for (int i = 0; i < 12; i++) push_word(DATA_W'($urandom));
    repeat (3) tick();
    x0 = xfers; cnt0 = rd_count;
    m_ready = 1'b1;
    ena = 1'b1;
    runc = $urandom_range(2, 8);
    repeat (runc) tick();
    ena = 1'b0;
    for (int c = 0; c < 60; c++) begin
      m_ready = ($urandom_range(0, 1) != 0);
      @(negedge rd_clk);
      if (busy === 1'b0) break;
      tick();
    end
    tick();
    m_ready = 1'b1;
    popped = 12 - fifo_q.size();
    @(negedge rd_clk);
    n_checks++;
    if (busy !== 1'b0 || xfers - x0 != popped) begin
      n_fail++; $display("FAIL drain_random: busy=%b delivered=%0d required 0/%0d", busy, xfers - x0, popped);
    end
`ifdef FIFO_RD_CNT_EN
    n_checks++;
    if (rd_count !== cnt0 + CNT_W'(popped)) begin
      n_fail++; $display("FAIL drain_random_count: got %0d required %0d", rd_count, cnt0 + CNT_W'(popped));
    end
`endif
    tick();
    fifo_q.delete();
    exp_q.delete();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(DATA_W'(8'hC0 + i));
    repeat (3) tick();
    ena = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    ena = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    @(posedge rd_clk);
    @(negedge rd_clk);
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || rd_count !== '0) begin
      n_fail++; $display("FAIL reset_mid: m_valid=%b busy=%b rd_en=%b rd_count=%0d required 0/0/0/0",
                         m_valid, busy, fifo_rd_en, rd_count);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge rd_clk);
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_after: m_valid=%b busy=%b required 0/0", m_valid, busy);
    end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_empty_edge();
    test_drain();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
